// File: rtl/router_arbiter.sv
// router_arbiter: round-robin arbiter that shares the single input port of the
// 4-way router among NUM_REQ requesters. A granted requester owns the router
// until its last beat, and every router-side output is registered.
module router_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]          req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         din,
    output logic                          din_en,
    output logic [1:0]                    addr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [1:0]              dst_q, dst_d;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    din_en_q;
    logic [1:0]              addr_q;

    logic                    ownerValid;
    logic                    ownerLast;
    logic [DATA_WIDTH-1:0]   ownerData;
    logic                    xfer;
    logic                    lastXfer;
    logic [IDX_W-1:0]        nextPtr;
    logic [IDX_W-1:0]        searchStart;
    logic [NUM_REQ-1:0]      arbReq;
    logic                    winnerFound;
    logic [IDX_W-1:0]        winner;
    logic [NUM_REQ-1:0]      winnerOneHot;
    logic [1:0]              winnerAddr;

    // Select the current owner's handshake and data lanes.
    always_comb begin
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        ownerData  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                ownerValid = req_valid[k];
                ownerLast  = req_last[k];
                ownerData  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer     = (state_q == BUSY) && ownerValid;
    assign lastXfer = xfer && ownerLast;
    assign nextPtr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // While a packet is open the next search begins just past the owner;
    // otherwise it begins at the stored round-robin pointer.
    always_comb begin
        searchStart = ptr_q;
        if (state_q == BUSY) begin
            searchStart = nextPtr;
        end
    end

    // The owner's valid during its last-beat cycle belongs to the beat being
    // consumed, so it is hidden from arbitration; with a single requester it
    // is left visible so back-to-back packets keep the grant with no bubble.
    always_comb begin
        arbReq = req_valid;
        if ((NUM_REQ > 1) && lastXfer) begin
            arbReq = req_valid & ~grant_q;
        end
    end

    // Round-robin search: first requesting index at or after searchStart.
    always_comb begin
        int idx;
        idx         = 0;
        winnerFound = 1'b0;
        winner      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(searchStart) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!winnerFound && arbReq[idx]) begin
                winnerFound = 1'b1;
                winner      = IDX_W'(idx);
            end
        end
    end

    // Decode the winner into a one-hot grant and pick up its destination.
    always_comb begin
        winnerOneHot = '0;
        winnerAddr   = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDX_W'(k)) begin
                winnerOneHot[k] = 1'b1;
                winnerAddr      = req_addr[k*2 +: 2];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: open a packet on any request, close when the last beat
    // leaves and nobody else is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (lastXfer && !winnerFound) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only the owner may see ready, and only while a packet is open.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == BUSY) begin
            req_ready = grant_q & req_valid;
            busy      = 1'b1;
        end
    end

    // Next grant, owner, destination and pointer.
    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        dst_d   = dst_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (winnerFound) begin
                grant_d = winnerOneHot;
                owner_d = winner;
                dst_d   = winnerAddr;
            end
        end else if (lastXfer) begin
            ptr_d = nextPtr;
            if (winnerFound) begin
                grant_d = winnerOneHot;
                owner_d = winner;
                dst_d   = winnerAddr;
            end else begin
                grant_d = '0;
            end
        end
    end

    // Arbitration bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            owner_q <= '0;
            dst_q   <= 2'd0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            dst_q   <= dst_d;
            ptr_q   <= ptr_d;
        end
    end

    // Router-side outputs: one cycle after a transfer, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q    <= '0;
            din_en_q <= 1'b0;
            addr_q   <= 2'd0;
        end else begin
            din_q    <= xfer ? ownerData : '0;
            din_en_q <= xfer;
            addr_q   <= xfer ? dst_q : 2'd0;
        end
    end

    assign grant  = grant_q;
    assign din    = din_q;
    assign din_en = din_en_q;
    assign addr   = addr_q;

endmodule

// File: tb/tb_router_arbiter.sv
// tb_router_arbiter: directed bench for router_arbiter. Per-requester beat
// queues feed a driver; expected router beats go into a scoreboard queue that
// a monitor drains whenever din_en is seen high.
module tb_router_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR*2-1:0]   req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [DW-1:0]     din;
    logic              din_en;
    logic [1:0]        addr;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  addr;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  addr;
    } exp_t;

    beat_t         txQ[NR][$];
    exp_t          expQ[$];
    int            gapCnt[NR];
    bit            headLoaded[NR];
    logic [NR-1:0] acc;
    bit            monEn;
    int            checkCount = 0;
    int            passCount  = 0;

    router_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .din       (din),
        .din_en    (din_en),
        .addr      (addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushBeat(input int r, input logic [31:0] d, input logic [1:0] a,
                            input logic l, input int g);
        beat_t b;
        b.data = d;
        b.addr = a;
        b.last = l;
        b.gap  = g;
        txQ[r].push_back(b);
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [1:0] a);
        exp_t e;
        e.data = d;
        e.addr = a;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic flushRequesters();
        for (int i = 0; i < NR; i++) begin
            txQ[i].delete();
            headLoaded[i] = 1'b0;
            gapCnt[i]     = 0;
        end
        acc = '0;
    endtask

    // Requester driver: retire accepted beats, then present each queue head.
    initial begin
        for (int i = 0; i < NR; i++) begin
            gapCnt[i]     = 0;
            headLoaded[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && txQ[i].size() > 0) begin
                    void'(txQ[i].pop_front());
                    headLoaded[i] = 1'b0;
                end
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_addr[i*2 +: 2]   = 2'd0;
                if (txQ[i].size() > 0) begin
                    if (!headLoaded[i]) begin
                        gapCnt[i]     = txQ[i][0].gap;
                        headLoaded[i] = 1'b1;
                    end
                    if (gapCnt[i] > 0) begin
                        gapCnt[i]--;
                    end else begin
                        req_valid[i]         = 1'b1;
                        req_last[i]          = txQ[i][0].last;
                        req_data[i*DW +: DW] = txQ[i][0].data;
                        req_addr[i*2 +: 2]   = txQ[i][0].addr;
                    end
                end
            end
        end
    end

    // Monitor: record handshakes and score every router-side output cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (monEn) begin
                if (din_en === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL unexpected beat: got din=%h addr=%0d, expected no beat", din, addr);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat data", din, e.data);
                        checkOutput("beat addr", 32'(addr), 32'(e.addr));
                    end
                end else begin
                    checkOutput("idle din", din, 32'h0);
                    checkOutput("idle addr", 32'(addr), 32'h0);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        logic [3:0] fairGrant[9];
        logic       fairEn[9];
        logic [3:0] lockGrant[5];
        logic [3:0] gapGrant[6];
        logic       gapEn[6];

        fairGrant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                      4'b0010, 4'b0100, 4'b1000, 4'b0000};
        fairEn    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        lockGrant = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        gapGrant  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        gapEn     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        req_addr  = '0;
        acc       = '0;
        monEn     = 1'b0;

        // Reset with all four requesters waiting, two single-beat packets each.
        pushBeat(0, 32'h11110000, 2'd0, 1'b1, 0);
        pushBeat(1, 32'h22220001, 2'd1, 1'b1, 0);
        pushBeat(2, 32'h33330002, 2'd2, 1'b1, 0);
        pushBeat(3, 32'h44440003, 2'd3, 1'b1, 0);
        pushBeat(0, 32'h1111AAAA, 2'd3, 1'b1, 0);
        pushBeat(1, 32'h2222BBBB, 2'd2, 1'b1, 0);
        pushBeat(2, 32'h3333CCCC, 2'd1, 1'b1, 0);
        pushBeat(3, 32'h4444DDDD, 2'd0, 1'b1, 0);
        pushExp(32'h11110000, 2'd0);
        pushExp(32'h22220001, 2'd1);
        pushExp(32'h33330002, 2'd2);
        pushExp(32'h44440003, 2'd3);
        pushExp(32'h1111AAAA, 2'd3);
        pushExp(32'h2222BBBB, 2'd2);
        pushExp(32'h3333CCCC, 2'd1);
        pushExp(32'h4444DDDD, 2'd0);

        @(posedge clk);
        #1;
        monEn = 1'b1;
        repeat (3) step();
        checkOutput("reset grant", 32'(grant), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset din_en", 32'(din_en), 32'h0);
        checkOutput("reset din", din, 32'h0);
        checkOutput("reset addr", 32'(addr), 32'h0);
        checkOutput("reset req_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;

        // Fairness: grants rotate 0,1,2,3,0,... with one leading bubble.
        for (int k = 0; k < 9; k++) begin
            step();
            checkOutput($sformatf("fair grant %0d", k), 32'(grant), 32'(fairGrant[k]));
            checkOutput($sformatf("fair din_en %0d", k), 32'(din_en), 32'(fairEn[k]));
        end
        checkOutput("fair busy at end", 32'(busy), 32'h0);
        step();
        checkOutput("fair din_en after", 32'(din_en), 32'h0);
        step();

        // Single request from requester 2.
        pushBeat(2, 32'hDEADBEEF, 2'd3, 1'b1, 0);
        pushExp(32'hDEADBEEF, 2'd3);
        step();
        step();
        checkOutput("single grant", 32'(grant), 32'h4);
        checkOutput("single busy", 32'(busy), 32'h1);
        checkOutput("single bubble din_en", 32'(din_en), 32'h0);
        step();
        checkOutput("single din_en", 32'(din_en), 32'h1);
        checkOutput("single grant after", 32'(grant), 32'h0);
        checkOutput("single busy after", 32'(busy), 32'h0);
        step();
        checkOutput("single din_en after", 32'(din_en), 32'h0);

        // Burst lock: requester 0 keeps addr 1 for all three beats.
        pushBeat(0, 32'hB0000001, 2'd1, 1'b0, 0);
        pushBeat(0, 32'hB0000002, 2'd2, 1'b0, 0);
        pushBeat(0, 32'hB0000003, 2'd1, 1'b1, 0);
        pushBeat(1, 32'hC0000001, 2'd0, 1'b1, 0);
        pushExp(32'hB0000001, 2'd1);
        pushExp(32'hB0000002, 2'd1);
        pushExp(32'hB0000003, 2'd1);
        pushExp(32'hC0000001, 2'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("lock grant %0d", k), 32'(grant), 32'(lockGrant[k]));
        end
        step();

        // Gap: requester 1 idles for two cycles before its second beat.
        pushBeat(1, 32'h40000001, 2'd0, 1'b0, 0);
        pushBeat(1, 32'h40000002, 2'd0, 1'b0, 2);
        pushBeat(1, 32'h40000003, 2'd0, 1'b1, 0);
        pushExp(32'h40000001, 2'd0);
        pushExp(32'h40000002, 2'd0);
        pushExp(32'h40000003, 2'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            checkOutput($sformatf("gap grant %0d", k), 32'(grant), 32'(gapGrant[k]));
            checkOutput($sformatf("gap din_en %0d", k), 32'(din_en), 32'(gapEn[k]));
        end
        step();

        // Reset on beat 2 of a 4-beat burst from requester 1.
        pushBeat(1, 32'h50000001, 2'd2, 1'b0, 0);
        pushBeat(1, 32'h50000002, 2'd2, 1'b0, 0);
        pushBeat(1, 32'h50000003, 2'd2, 1'b0, 0);
        pushBeat(1, 32'h50000004, 2'd2, 1'b1, 0);
        pushExp(32'h50000001, 2'd2);
        step();
        step();
        checkOutput("midreset grant before", 32'(grant), 32'h2);
        step();
        checkOutput("midreset beat1 din_en", 32'(din_en), 32'h1);
        reset = 1'b1;
        flushRequesters();
        step();
        checkOutput("midreset grant", 32'(grant), 32'h0);
        checkOutput("midreset busy", 32'(busy), 32'h0);
        checkOutput("midreset din_en", 32'(din_en), 32'h0);
        checkOutput("midreset req_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;

        // Pointer is back at 0: requester 0 beats requester 2.
        pushBeat(0, 32'h60000000, 2'd1, 1'b1, 0);
        pushBeat(2, 32'h60000002, 2'd3, 1'b1, 0);
        pushExp(32'h60000000, 2'd1);
        pushExp(32'h60000002, 2'd3);
        step();
        checkOutput("postreset din_en", 32'(din_en), 32'h0);
        step();
        checkOutput("postreset grant first", 32'(grant), 32'h1);
        step();
        checkOutput("postreset grant second", 32'(grant), 32'h4);
        step();
        checkOutput("postreset grant idle", 32'(grant), 32'h0);
        checkOutput("postreset busy idle", 32'(busy), 32'h0);
        repeat (3) step();
    endtask

    initial begin
        applyStimulus();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
